// File: rtl/decode_stage.sv
// Purpose: MIPS-style ID stage: register file with write-back bypass, control
//          decode, sign extension, load-use stall detection and ID/EX register.
// Latency: 1 cycle from IF/ID to all *_id_ex outputs; stall is combinational.
// Backpressure: stall holds PC and IF/ID upstream; a bubble enters ID/EX on stall or flush.
// Ports: clk/reset (sync, active-high); IF/ID instruction and PC+4; flush;
//        write-back port (wb_*); stall out; registered ID/EX operands, offset, PC+4,
//        rt/rd indices and control bits.
module decode_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instruction_if_id,
    input  logic [31:0] supposed_next_address_if_id,
    input  logic        flush,
    input  logic        wb_reg_write,
    input  logic [4:0]  wb_write_register,
    input  logic [31:0] wb_write_data,
    output logic        stall,
    output logic [31:0] read_data_1_id_ex,
    output logic [31:0] read_data_2_id_ex,
    output logic [31:0] extended_branch_offset_id_ex,
    output logic [31:0] supposed_next_address_id_ex,
    output logic [4:0]  next_instruction_20_16_id_ex,
    output logic [4:0]  next_instruction_15_11_id_ex,
    output logic [1:0]  ctrl_aluOp_id_ex,
    output logic        ctrl_aluSrc_id_ex,
    output logic        ctrl_regDest_id_ex,
    output logic        ctrl_memRead_id_ex,
    output logic        ctrl_memWrite_id_ex,
    output logic        ctrl_memToReg_id_ex,
    output logic        ctrl_regWrite_id_ex,
    output logic        ctrl_branch_id_ex
);

    logic [31:0] regs [0:31];

    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        wb_active;
    logic [31:0] rs_data;
    logic [31:0] rt_data;

    assign opcode    = instruction_if_id[31:26];
    assign rs        = instruction_if_id[25:21];
    assign rt        = instruction_if_id[20:16];
    assign rd        = instruction_if_id[15:11];
    assign wb_active = wb_reg_write && (wb_write_register != 5'd0);

    // Register read with same-cycle write-back forwarding; r0 is hardwired to zero.
    always_comb begin
        rs_data = regs[rs];
        rt_data = regs[rt];
        if (wb_active && (wb_write_register == rs)) rs_data = wb_write_data;
        if (wb_active && (wb_write_register == rt)) rt_data = wb_write_data;
        if (rs == 5'd0) rs_data = 32'd0;
        if (rt == 5'd0) rt_data = 32'd0;
    end

    // Control decode: {regDest, aluSrc, memToReg, regWrite, memRead, memWrite, branch, aluOp[1:0]}
    logic [8:0] ctrl;
    always_comb begin
        ctrl = 9'b0;
        case (opcode)
            6'b000000: ctrl = 9'b1_0_0_1_0_0_0_10;
            6'b100011: ctrl = 9'b0_1_1_1_1_0_0_00;
            6'b101011: ctrl = 9'b0_1_0_0_0_1_0_00;
            6'b000100: ctrl = 9'b0_0_0_0_0_0_1_01;
            6'b001000: ctrl = 9'b0_1_0_1_0_0_0_00;
            default:   ctrl = 9'b0;
        endcase
    end

    // Load-use: the load now in ID/EX targets a register this instruction reads.
    // Once the bubble is in ID/EX, memRead drops and the stall releases itself.
    assign stall = !reset && !flush && ctrl_memRead_id_ex &&
                   (next_instruction_20_16_id_ex != 5'd0) &&
                   ((next_instruction_20_16_id_ex == rs) ||
                    (next_instruction_20_16_id_ex == rt));

    logic bubble;
    assign bubble = flush || stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
            read_data_1_id_ex            <= 32'd0;
            read_data_2_id_ex            <= 32'd0;
            extended_branch_offset_id_ex <= 32'd0;
            supposed_next_address_id_ex  <= 32'd0;
            next_instruction_20_16_id_ex <= 5'd0;
            next_instruction_15_11_id_ex <= 5'd0;
            ctrl_regDest_id_ex           <= 1'b0;
            ctrl_aluSrc_id_ex            <= 1'b0;
            ctrl_memToReg_id_ex          <= 1'b0;
            ctrl_regWrite_id_ex          <= 1'b0;
            ctrl_memRead_id_ex           <= 1'b0;
            ctrl_memWrite_id_ex          <= 1'b0;
            ctrl_branch_id_ex            <= 1'b0;
            ctrl_aluOp_id_ex             <= 2'b00;
        end else begin
            if (wb_active) regs[wb_write_register] <= wb_write_data;
            read_data_1_id_ex            <= rs_data;
            read_data_2_id_ex            <= rt_data;
            extended_branch_offset_id_ex <= {{16{instruction_if_id[15]}}, instruction_if_id[15:0]};
            supposed_next_address_id_ex  <= supposed_next_address_if_id;
            next_instruction_20_16_id_ex <= rt;
            next_instruction_15_11_id_ex <= rd;
            // Data fields load regardless; only control is squashed into a bubble.
            {ctrl_regDest_id_ex, ctrl_aluSrc_id_ex, ctrl_memToReg_id_ex,
             ctrl_regWrite_id_ex, ctrl_memRead_id_ex, ctrl_memWrite_id_ex,
             ctrl_branch_id_ex, ctrl_aluOp_id_ex} <= bubble ? 9'b0 : ctrl;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instruction_if_id;
    logic [31:0] supposed_next_address_if_id;
    logic        flush;
    logic        wb_reg_write;
    logic [4:0]  wb_write_register;
    logic [31:0] wb_write_data;
    logic        stall;
    logic [31:0] read_data_1_id_ex, read_data_2_id_ex;
    logic [31:0] extended_branch_offset_id_ex, supposed_next_address_id_ex;
    logic [4:0]  next_instruction_20_16_id_ex, next_instruction_15_11_id_ex;
    logic [1:0]  ctrl_aluOp_id_ex;
    logic        ctrl_aluSrc_id_ex, ctrl_regDest_id_ex, ctrl_memRead_id_ex, ctrl_memWrite_id_ex;
    logic        ctrl_memToReg_id_ex, ctrl_regWrite_id_ex, ctrl_branch_id_ex;

    decode_stage dut (
        .clk(clk), .reset(reset),
        .instruction_if_id(instruction_if_id),
        .supposed_next_address_if_id(supposed_next_address_if_id),
        .flush(flush),
        .wb_reg_write(wb_reg_write), .wb_write_register(wb_write_register),
        .wb_write_data(wb_write_data),
        .stall(stall),
        .read_data_1_id_ex(read_data_1_id_ex), .read_data_2_id_ex(read_data_2_id_ex),
        .extended_branch_offset_id_ex(extended_branch_offset_id_ex),
        .supposed_next_address_id_ex(supposed_next_address_id_ex),
        .next_instruction_20_16_id_ex(next_instruction_20_16_id_ex),
        .next_instruction_15_11_id_ex(next_instruction_15_11_id_ex),
        .ctrl_aluOp_id_ex(ctrl_aluOp_id_ex), .ctrl_aluSrc_id_ex(ctrl_aluSrc_id_ex),
        .ctrl_regDest_id_ex(ctrl_regDest_id_ex), .ctrl_memRead_id_ex(ctrl_memRead_id_ex),
        .ctrl_memWrite_id_ex(ctrl_memWrite_id_ex), .ctrl_memToReg_id_ex(ctrl_memToReg_id_ex),
        .ctrl_regWrite_id_ex(ctrl_regWrite_id_ex), .ctrl_branch_id_ex(ctrl_branch_id_ex)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: architectural register contents plus expected ID/EX contents.
    logic [31:0] m_regs [32];
    logic [31:0] m_rd1, m_rd2, m_off, m_pc;
    logic [4:0]  m_rt, m_rd;
    logic        m_regDest, m_aluSrc, m_memToReg, m_regWrite, m_memRead, m_memWrite, m_branch;
    logic [1:0]  m_aluOp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Operand value as seen by an instruction in ID this cycle.
    function automatic logic [31:0] m_read(input logic [4:0] r);
        if (r == 0) return 32'd0;
        if (wb_reg_write && wb_write_register == r) return wb_write_data;
        return m_regs[r];
    endfunction

    function automatic logic m_stall();
        logic [4:0] s, t;
        s = instruction_if_id[25:21];
        t = instruction_if_id[20:16];
        return !reset && !flush && m_memRead && m_rt != 0 && (m_rt == s || m_rt == t);
    endfunction

    task automatic m_reset_outputs();
        m_rd1 = 0; m_rd2 = 0; m_off = 0; m_pc = 0; m_rt = 0; m_rd = 0;
        {m_regDest, m_aluSrc, m_memToReg, m_regWrite, m_memRead, m_memWrite, m_branch} = 7'b0;
        m_aluOp = 2'b00;
    endtask

    task automatic compare_outputs();
        chk("rd1", read_data_1_id_ex, m_rd1);
        chk("rd2", read_data_2_id_ex, m_rd2);
        chk("offset", extended_branch_offset_id_ex, m_off);
        chk("pc4", supposed_next_address_id_ex, m_pc);
        chk("rt", {27'd0, next_instruction_20_16_id_ex}, {27'd0, m_rt});
        chk("rd", {27'd0, next_instruction_15_11_id_ex}, {27'd0, m_rd});
        chk("ctrl", {23'd0, ctrl_regDest_id_ex, ctrl_aluSrc_id_ex, ctrl_memToReg_id_ex,
                     ctrl_regWrite_id_ex, ctrl_memRead_id_ex, ctrl_memWrite_id_ex,
                     ctrl_branch_id_ex, ctrl_aluOp_id_ex},
            {23'd0, m_regDest, m_aluSrc, m_memToReg, m_regWrite, m_memRead, m_memWrite,
             m_branch, m_aluOp});
    endtask

    // Called just after a falling edge with inputs driven: check stall, step through
    // the rising edge, check ID/EX, then return at the next falling edge.
    task automatic tick();
        logic        st, bub;
        logic [5:0]  op;
        logic [31:0] n_rd1, n_rd2;
        #1;
        st = m_stall();
        chk("stall", {31'd0, stall}, {31'd0, st});
        n_rd1 = m_read(instruction_if_id[25:21]);
        n_rd2 = m_read(instruction_if_id[20:16]);
        op    = instruction_if_id[31:26];
        bub   = flush || st;
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 0;
            m_reset_outputs();
        end else begin
            m_rd1 = n_rd1;
            m_rd2 = n_rd2;
            m_off = {{16{instruction_if_id[15]}}, instruction_if_id[15:0]};
            m_pc  = supposed_next_address_if_id;
            m_rt  = instruction_if_id[20:16];
            m_rd  = instruction_if_id[15:11];
            {m_regDest, m_aluSrc, m_memToReg, m_regWrite, m_memRead, m_memWrite, m_branch} = 7'b0;
            m_aluOp = 2'b00;
            if (!bub) begin
                if (op == 6'b000000) begin m_regDest = 1; m_regWrite = 1; m_aluOp = 2'b10; end
                if (op == 6'b100011) begin m_aluSrc = 1; m_memToReg = 1; m_regWrite = 1; m_memRead = 1; end
                if (op == 6'b101011) begin m_aluSrc = 1; m_memWrite = 1; end
                if (op == 6'b000100) begin m_branch = 1; m_aluOp = 2'b01; end
                if (op == 6'b001000) begin m_aluSrc = 1; m_regWrite = 1; end
            end
            if (wb_reg_write && wb_write_register != 0) m_regs[wb_write_register] = wb_write_data;
        end
        #1;
        compare_outputs();
        @(negedge clk);
    endtask

    task automatic drive(input logic [31:0] instr, input logic we, input logic [4:0] wr,
                         input logic [31:0] wd, input logic fl);
        instruction_if_id = instr;
        wb_reg_write      = we;
        wb_write_register = wr;
        wb_write_data     = wd;
        flush             = fl;
        supposed_next_address_if_id = supposed_next_address_if_id + 4;
    endtask

    initial begin
        logic [31:0] instr;
        logic [5:0]  ops [6];
        ops[0] = 6'b000000; ops[1] = 6'b100011; ops[2] = 6'b101011;
        ops[3] = 6'b000100; ops[4] = 6'b001000; ops[5] = 6'b111111;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'hx;
        m_reset_outputs();
        reset = 1; supposed_next_address_if_id = 32'h100;
        drive(32'h0108_4820, 1, 5'd9, 32'h55, 0);
        @(negedge clk);
        tick();
        chk("reset rd1", read_data_1_id_ex, 32'd0);
        chk("reset ctrl regWrite", {31'd0, ctrl_regWrite_id_ex}, 32'd0);
        reset = 0;

        // Write r8 then add r9,r8,r8
        drive(32'hFC00_0000, 1, 5'd8, 32'h0000_1234, 0); tick();
        drive(32'h0108_4820, 0, 5'd0, 32'h0, 0); tick();
        chk("wb-read rd1", read_data_1_id_ex, 32'h1234);
        chk("wb-read rd2", read_data_2_id_ex, 32'h1234);
        chk("wb-read regDest", {31'd0, ctrl_regDest_id_ex}, 32'd1);
        chk("wb-read aluOp", {30'd0, ctrl_aluOp_id_ex}, 32'd2);
        chk("wb-read rd idx", {27'd0, next_instruction_15_11_id_ex}, 32'd9);

        // Same-cycle bypass: sw r5,4(r0)
        drive(32'hAC05_0004, 1, 5'd5, 32'hDEAD_BEEF, 0); tick();
        chk("bypass rd2", read_data_2_id_ex, 32'hDEAD_BEEF);
        chk("bypass offset", extended_branch_offset_id_ex, 32'h4);
        chk("bypass memWrite", {31'd0, ctrl_memWrite_id_ex}, 32'd1);

        // beq r1,r2,-1
        drive(32'h1022_FFFF, 0, 5'd0, 32'h0, 0); tick();
        chk("sext offset", extended_branch_offset_id_ex, 32'hFFFF_FFFF);
        chk("sext branch", {31'd0, ctrl_branch_id_ex}, 32'd1);
        chk("sext aluOp", {30'd0, ctrl_aluOp_id_ex}, 32'd1);

        // Load-use: lw r3,0(r0); add r4,r3,r1
        drive(32'h8C03_0000, 0, 5'd0, 32'h0, 0); tick();
        drive(32'h0061_2020, 0, 5'd0, 32'h0, 0);
        #1 chk("load-use stall", {31'd0, stall}, 32'd1);
        tick();
        chk("load-use bubble", {31'd0, ctrl_regWrite_id_ex | ctrl_regDest_id_ex}, 32'd0);
        chk("load-use release", {31'd0, stall}, 32'd0);
        tick();
        chk("load-use issue", {31'd0, ctrl_regWrite_id_ex}, 32'd1);

        // Flush beats stall
        drive(32'h8C03_0000, 0, 5'd0, 32'h0, 0); tick();
        drive(32'h0061_2020, 0, 5'd0, 32'h0, 1);
        #1 chk("flush no stall", {31'd0, stall}, 32'd0);
        tick();
        chk("flush bubble", {31'd0, ctrl_regWrite_id_ex}, 32'd0);

        // r0 ignores writes (including bypass)
        drive(32'h0000_0000, 1, 5'd0, 32'h5, 0); tick();
        chk("r0 bypass", read_data_1_id_ex, 32'd0);
        drive(32'h0000_0000, 0, 5'd0, 32'h0, 0); tick();
        chk("r0 read", read_data_1_id_ex, 32'd0);

        // Reset clears registers and outputs; reset mid-stall
        drive(32'h0000_0000, 1, 5'd7, 32'h77, 0); tick();
        drive(32'h8C07_0000, 0, 5'd0, 32'h0, 0); tick();
        reset = 1;
        drive(32'h00E7_3820, 1, 5'd7, 32'h99, 1);
        #1 chk("reset stall", {31'd0, stall}, 32'd0);
        tick();
        chk("reset pc4", supposed_next_address_id_ex, 32'd0);
        reset = 0;
        drive(32'h00E7_3820, 0, 5'd0, 32'h0, 0);
        #1 chk("post-reset stall", {31'd0, stall}, 32'd0);
        tick();
        chk("r7 cleared", read_data_1_id_ex, 32'd0);

        // Randomized traffic; small register range provokes hazards and bypasses.
        for (int n = 0; n < 3000; n++) begin
            if (!m_stall()) begin
                instr = $urandom;
                instr[31:26] = ops[$urandom_range(0, 5)];
                instr[25:21] = 5'($urandom_range(0, 7));
                instr[20:16] = 5'($urandom_range(0, 7));
                instruction_if_id = instr;
                supposed_next_address_if_id = supposed_next_address_if_id + 4;
            end
            wb_reg_write      = ($urandom_range(0, 1) == 1);
            wb_write_register = 5'($urandom_range(0, 7));
            wb_write_data     = $urandom;
            flush             = ($urandom_range(0, 9) == 0);
            reset             = ($urandom_range(0, 49) == 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
